multi_app_injector: RTL and testbench
=====================================

Name: multi_app_injector

Overview:
- Synthesisable, parametrised successor to the simulation-only application injector.
- Merges N_SRC independent packet streams into one credit-flow-controlled NoC injection port.
- Each source streams whole packets (header flit carrying payload length, then payload).
- Packets are arbitrated round-robin, never interleaved, buffered in an output FIFO and driven on tx_o/data_o under credit_i; eoa_o flags end of all applications.

Parameters:
- FLIT_SIZE, 32, flit width in bits.
- N_SRC, 4, number of source channels (>=1).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- LEN_WIDTH, 16, header bits [LEN_WIDTH-1:0] holding payload length L (LEN_WIDTH <= FLIT_SIZE).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- src_valid_i  in  N_SRC  per-source flit valid.
- src_data_i  in  N_SRC*FLIT_SIZE  per-source flit; source s occupies bits [s*FLIT_SIZE +: FLIT_SIZE].
- src_ready_o  out  N_SRC  per-source accept, one-hot or zero.
- src_done_i  in  N_SRC  level; source has no further packets.
- tx_o  out  1  output flit valid.
- credit_i  in  1  downstream credit; a flit transfers on a rising edge with tx_o && credit_i.
- data_o  out  FLIT_SIZE  output flit.
- grant_o  out  max(1,$clog2(N_SRC))  currently or last granted source.
- busy_o  out  1  FSM not IDLE or FIFO not empty.
- eoa_o  out  1  end of all applications, sticky.

Behaviour:
- Reset: state IDLE, RR pointer 0, FIFO empty, length counter 0. All outputs 0: tx_o, data_o, src_ready_o, grant_o, busy_o, eoa_o.
- Reset mid-packet discards the partial packet and FIFO contents. No recovery of the partial packet.
- Source accept: a flit is accepted from s on an edge with src_valid_i[s] && src_ready_o[s].
- src_ready_o[s] = (state in HDR/BODY) && (grant == s) && !fifo_full. Readiness is not conditioned on src_valid_i.
- IDLE: if any src_valid_i, grant the first valid source at or after the RR pointer (wrapping), then go to HDR. One cycle grant latency.
- HDR: on accept, push the header flit and load cnt = header[LEN_WIDTH-1:0]. If cnt == 0, go to IDLE; else go to BODY.
- BODY: each accept pushes the flit and decrements cnt. The accept with cnt == 1 is the last; go to IDLE.
- On leaving a packet, RR pointer = grant+1, wrapping N_SRC-1 -> 0.
- A source dropping valid mid-packet stalls the FSM; no timeout, grant held.
- FIFO push and pop in the same cycle leaves the count unchanged.
- Full FIFO: push is blocked via ready; no bypass.
- Output: tx_o = !fifo_empty. data_o = FIFO head and is held stable until transfer.
- Output is first-word-fall-through: the earliest tx_o is the cycle after the first push.
- Empty FIFO: tx_o = 0, data_o holds its last value.
- Packet integrity: flits of different packets never interleave on data_o.
- eoa_o sets when, in one cycle: &src_done_i, state IDLE, FIFO empty, and no src_valid_i. It remains 1 until reset.
- Valid arriving after eoa_o is ignored: no grants are issued once eoa_o = 1.

Optional Feature:
- Macro: MULTI_APP_INJECTOR_STATS_EN.
- Defined: adds outputs pkt_cnt_o [N_SRC*32] and flit_cnt_o [32].
  - pkt_cnt_o increments per source when that source's last flit is accepted into the FIFO.
  - flit_cnt_o increments per output transfer.
  - All counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single source 0, header L=3, payload A1..A3, credit_i always 1 -> data_o sequence 0x3, A1, A2, A3; tx_o high exactly 4 cycles; src_ready_o[0] drops to 0 after A3.
- Sources 0 and 2 valid together, each with L=1 -> src 0 packet fully output, then src 2; grant_o 0 then 2; next grant starts search at 3.
- credit_i held 0 for 10 cycles with FIFO_DEPTH=4 and L=7 -> exactly 4 flits accepted, src_ready_o = 0, data_o stable. Releasing credit_i drains all 8 flits in order.
- Header L=0 from source 1 -> one flit out, FSM back to IDLE; next packet from source 1 still served.
- rst_i asserted during BODY of an L=5 packet -> next cycle all outputs 0, FIFO empty; new packet after reset is output intact.
- All src_done_i=1 with FIFO draining -> eoa_o rises the cycle after the last transfer and stays 1. With STATS_EN, pkt_cnt_o and flit_cnt_o match the totals sent.

Source files
------------

// File: rtl/multi_app_injector.sv
// multi_app_injector: round-robin packet merger feeding a credit-flow NoC port.
// Optional statistics counters enabled by MULTI_APP_INJECTOR_STATS_EN.
module multi_app_injector #(
  parameter  int FLIT_SIZE  = 32,
  parameter  int N_SRC      = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int LEN_WIDTH  = 16,
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SRC-1:0]           src_valid_i,
  input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
  output logic [N_SRC-1:0]           src_ready_o,
  input  logic [N_SRC-1:0]           src_done_i,
  output logic                       tx_o,
  input  logic                       credit_i,
  output logic [FLIT_SIZE-1:0]       data_o,
  output logic [GW-1:0]              grant_o,
  output logic                       busy_o,
  output logic                       eoa_o
`ifdef MULTI_APP_INJECTOR_STATS_EN
  ,
  output logic [N_SRC*32-1:0]        pkt_cnt_o,
  output logic [31:0]                flit_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 eoa_q, eoa_d;

  logic [FLIT_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          count_q;
  logic [FLIT_SIZE-1:0] last_q;

  logic                 fifo_full, fifo_empty;
  logic                 in_pkt, acc, push, pop;
  logic [FLIT_SIZE-1:0] flit_in;
  logic                 pick_found;
  logic [GW-1:0]        pick_idx;
  logic [GW-1:0]        rr_next;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_pkt     = (state_q == S_HDR) || (state_q == S_BODY);
  assign flit_in    = src_data_i[int'(grant_q)*FLIT_SIZE +: FLIT_SIZE];

  assign src_ready_o = (in_pkt && !fifo_full) ? (N_SRC'(1) << grant_q) : '0;
  assign acc  = |(src_ready_o & src_valid_i);
  assign push = acc;
  assign pop  = !fifo_empty && credit_i;

  assign tx_o    = !fifo_empty;
  assign data_o  = fifo_empty ? last_q : mem_q[rd_q];
  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE) || !fifo_empty;
  assign eoa_o   = eoa_q;

  assign rr_next = GW'((int'(grant_q) + 1) % N_SRC);

  // first valid source at or after the round-robin pointer, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      int j;
      j = (int'(rr_q) + i) % N_SRC;
      if (!pick_found && src_valid_i[j]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(j);
      end
    end
  end

  // packet framing FSM: grant, header, body
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found && !eoa_q) begin
          grant_d = pick_idx;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (acc) begin
          cnt_d = flit_in[LEN_WIDTH-1:0];
          if (flit_in[LEN_WIDTH-1:0] == '0) begin
            state_d = S_IDLE;
            rr_d    = rr_next;
          end else begin
            state_d = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (acc) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_IDLE;
            rr_d    = rr_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // end of applications: sticky once every source is done and all is quiet
  always_comb begin
    eoa_d = eoa_q;
    if (&src_done_i && state_q == S_IDLE && fifo_empty && !(|src_valid_i))
      eoa_d = 1'b1;
  end

  // control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      eoa_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      eoa_q   <= eoa_d;
    end
  end

  // FIFO storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= flit_in;
  end

  // FIFO pointers, occupancy and last-driven flit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifdef MULTI_APP_INJECTOR_STATS_EN
  logic [31:0] pkt_cnt_q [N_SRC];
  logic [31:0] flit_cnt_q;
  logic        last_acc;

  assign last_acc = acc &&
    ((state_q == S_HDR && flit_in[LEN_WIDTH-1:0] == '0) ||
     (state_q == S_BODY && cnt_q == LEN_WIDTH'(1)));

  // saturating per-source packet and output flit counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < N_SRC; s++) pkt_cnt_q[s] <= '0;
      flit_cnt_q <= '0;
    end else begin
      if (last_acc && pkt_cnt_q[grant_q] != 32'hFFFF_FFFF)
        pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 1'b1;
      if (pop && flit_cnt_q != 32'hFFFF_FFFF)
        flit_cnt_q <= flit_cnt_q + 1'b1;
    end
  end

  always_comb begin
    pkt_cnt_o = '0;
    for (int s = 0; s < N_SRC; s++) pkt_cnt_o[s*32 +: 32] = pkt_cnt_q[s];
  end

  assign flit_cnt_o = flit_cnt_q;
`endif

endmodule

// File: tb/tb_multi_app_injector.sv
// tb_multi_app_injector: directed vectors for multi_app_injector.
// Expected values are hand-computed from the packets each step sends.
module tb_multi_app_injector;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   src_valid;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic [3:0]   src_done;
  logic         tx;
  logic         credit;
  logic [31:0]  data;
  logic [1:0]   grant;
  logic         busy;
  logic         eoa;
`ifdef MULTI_APP_INJECTOR_STATS_EN
  logic [127:0] pkt_cnt;
  logic [31:0]  flit_cnt;
`endif

  multi_app_injector dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_valid_i (src_valid),
    .src_data_i  (src_data),
    .src_ready_o (src_ready),
    .src_done_i  (src_done),
    .tx_o        (tx),
    .credit_i    (credit),
    .data_o      (data),
    .grant_o     (grant),
    .busy_o      (busy),
    .eoa_o       (eoa)
`ifdef MULTI_APP_INJECTOR_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt),
    .flit_cnt_o  (flit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  int txcnt = 0;
  logic [31:0] outq [$];
  logic [31:0] pk [$];
  logic [31:0] ex [$];

  always @(negedge clk) begin
    if (tx) txcnt++;
    if (tx && credit) outq.push_back(data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic [31:0] p [$],
                       input int start, input int maxc, output int idx);
    logic taken;
    idx = start;
    for (int c = 0; c < maxc && idx < p.size(); c++) begin
      src_valid[s] = 1'b1;
      src_data[s*32 +: 32] = p[idx];
      @(negedge clk);
      taken = src_ready[s];
      @(posedge clk);
      #1;
      if (taken) idx++;
    end
    src_valid[s] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!busy) done = 1'b1;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e [$]);
    chk({tag, "_len"}, outq.size(), e.size());
    for (int i = 0; i < e.size() && i < outq.size(); i++)
      chk($sformatf("%s_f%0d", tag, i), outq[i], e[i]);
    outq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    outq.delete();
    txcnt = 0;
  endtask

  initial begin
    int idx;
    logic ok;
    rst = 1'b1;
    credit = 1'b1;
    src_valid = '0;
    src_done = '0;
    src_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_ready", {28'd0, src_ready}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_eoa", {31'd0, eoa}, 32'd0);
    rst = 1'b0;
    outq.delete();
    txcnt = 0;

    // single source, L=3
    pk = '{32'h0000_0003, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
    drive(0, pk, 0, 50, idx);
    chk("t1_taken", idx, 4);
    chk("t1_ready_drop", {28'd0, src_ready}, 32'd0);
    wait_idle("t1_idle");
    expect_out("t1", pk);
    chk("t1_txcycles", txcnt, 4);

    // sources 0 and 2 together, L=1 each
    do_reset();
    src_valid[2] = 1'b1;
    src_data[64 +: 32] = 32'h2000_0001;
    pk = '{32'h1000_0001, 32'h0000_00B1};
    drive(0, pk, 0, 50, idx);
    chk("t2_taken0", idx, 2);
    chk("t2_grant0", {30'd0, grant}, 32'd0);
    pk = '{32'h2000_0001, 32'h0000_00C1};
    drive(2, pk, 0, 50, idx);
    chk("t2_taken2", idx, 2);
    chk("t2_grant2", {30'd0, grant}, 32'd2);
    wait_idle("t2_idle");
    ex = '{32'h1000_0001, 32'h0000_00B1, 32'h2000_0001, 32'h0000_00C1};
    expect_out("t2", ex);

    // pointer now at 3: sources 0 and 3 compete, 3 wins
    src_valid[0] = 1'b1;
    src_data[0 +: 32] = 32'h0100_0000;
    pk = '{32'h3000_0000};
    drive(3, pk, 0, 50, idx);
    chk("t2b_grant3", {30'd0, grant}, 32'd3);
    pk = '{32'h0100_0000};
    drive(0, pk, 0, 50, idx);
    chk("t2b_grant0", {30'd0, grant}, 32'd0);
    wait_idle("t2b_idle");
    ex = '{32'h3000_0000, 32'h0100_0000};
    expect_out("t2b", ex);

    // credit stall with L=7 against a 4-entry FIFO
    credit = 1'b0;
    pk = '{32'h1100_0007, 32'h0000_00D1, 32'h0000_00D2, 32'h0000_00D3,
           32'h0000_00D4, 32'h0000_00D5, 32'h0000_00D6, 32'h0000_00D7};
    drive(1, pk, 0, 10, idx);
    chk("t3_stall_taken", idx, 4);
    chk("t3_stall_ready", {28'd0, src_ready}, 32'd0);
    chk("t3_stall_tx", {31'd0, tx}, 32'd1);
    chk("t3_stall_data", data, 32'h1100_0007);
    chk("t3_stall_noout", outq.size(), 0);
    credit = 1'b1;
    drive(1, pk, idx, 100, idx);
    chk("t3_taken", idx, 8);
    wait_idle("t3_idle");
    expect_out("t3", pk);

    // zero-length header, then same source again
    pk = '{32'h4100_0000};
    drive(1, pk, 0, 50, idx);
    chk("t4_ready_idle", {28'd0, src_ready}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    wait_idle("t4_idle");
    expect_out("t4", pk);
    chk("t4_tx_empty", {31'd0, tx}, 32'd0);
    chk("t4_data_hold", data, 32'h4100_0000);
    pk = '{32'h4200_0001, 32'h0000_00E1};
    drive(1, pk, 0, 50, idx);
    wait_idle("t4b_idle");
    expect_out("t4b", pk);

    // reset in the middle of an L=5 body
    pk = '{32'h5200_0005, 32'h0000_00F1, 32'h0000_00F2, 32'h0000_00F3,
           32'h0000_00F4, 32'h0000_00F5};
    drive(2, pk, 0, 3, idx);
    chk("t5_partial", idx, 2);
    chk("t5_pre_grant", {30'd0, grant}, 32'd2);
    do_reset();
    chk("t5_tx", {31'd0, tx}, 32'd0);
    chk("t5_data", data, 32'd0);
    chk("t5_ready", {28'd0, src_ready}, 32'd0);
    chk("t5_grant", {30'd0, grant}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_eoa", {31'd0, eoa}, 32'd0);
    pk = '{32'h5300_0002, 32'h0000_0AA1, 32'h0000_0AA2};
    drive(2, pk, 0, 50, idx);
    wait_idle("t5b_idle");
    expect_out("t5b", pk);

    // end of applications while the FIFO drains
    credit = 1'b0;
    pk = '{32'h6000_0001, 32'h0000_0BB1};
    drive(0, pk, 0, 50, idx);
    src_done = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_eoa_pending", {31'd0, eoa}, 32'd0);
    credit = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (!tx) ok = 1'b1;
    end
    chk("t6_drained", {31'd0, ok}, 32'd1);
    chk("t6_eoa_not_yet", {31'd0, eoa}, 32'd0);
    @(posedge clk);
    #1;
    chk("t6_eoa_rise", {31'd0, eoa}, 32'd1);
    src_valid[1] = 1'b1;
    src_data[32 +: 32] = 32'h7100_0001;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_eoa_sticky", {31'd0, eoa}, 32'd1);
    chk("t6_no_grant", {28'd0, src_ready}, 32'd0);
    chk("t6_no_tx", {31'd0, tx}, 32'd0);
    chk("t6_not_busy", {31'd0, busy}, 32'd0);
    src_valid = '0;
    expect_out("t6", pk);
`ifdef MULTI_APP_INJECTOR_STATS_EN
    chk("st_pkt0", pkt_cnt[0 +: 32], 32'd1);
    chk("st_pkt1", pkt_cnt[32 +: 32], 32'd0);
    chk("st_pkt2", pkt_cnt[64 +: 32], 32'd1);
    chk("st_pkt3", pkt_cnt[96 +: 32], 32'd0);
    chk("st_flits", flit_cnt, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
